// File: rtl/axis_rr_arbiter_if.sv
// Requester-side and FIFO-write-side AXI-Stream signals of axis_rr_arbiter.
// slave = the arbiter itself; master = whatever drives requesters and the FIFO ready.
interface axis_rr_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GW         = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS*DATA_WIDTH-1:0] m_tdata;
  logic [NUM_PORTS-1:0]            m_tvalid;
  logic [NUM_PORTS-1:0]            m_tready;
  logic [NUM_PORTS-1:0]            m_tlast;
  logic [DATA_WIDTH-1:0]           s_tdata;
  logic                            s_tvalid;
  logic                            s_tready;
  logic                            s_tlast;
  logic [GW-1:0]                   s_tid;

  modport slave (
    input  m_tdata, m_tvalid, m_tlast, s_tready,
    output m_tready, s_tdata, s_tvalid, s_tlast, s_tid
  );

  modport master (
    output m_tdata, m_tvalid, m_tlast, s_tready,
    input  m_tready, s_tdata, s_tvalid, s_tlast, s_tid
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin mux of NUM_PORTS AXI-Stream requesters onto one FIFO write port; grant 1 cycle after request.
// Grant is held until the tlast handshake; s_tready passes straight to the granted m_tready, so stalls hold the beat in place.
module axis_rr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [NUM_PORTS-1:0] port_en,
  axis_rr_arbiter_if.slave     bus,
  output logic                 busy,
  output logic                 pkt_done
);
  localparam int GW = $clog2(NUM_PORTS);
  localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 pkt_done_q, pkt_done_d;

  logic [NUM_PORTS-1:0] req;
  logic [GW-1:0]        sel;
  logic                 found;
  logic                 eop;
  int                   idx;

  // Circular search for the first enabled requester at or above rr_ptr.
  always_comb begin
    req   = bus.m_tvalid & port_en;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_PORTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  always_comb begin
    bus.s_tdata  = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tid    = '0;
    bus.m_tready = '0;
    busy         = 1'b0;
    eop          = 1'b0;
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    pkt_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = PKT;
          grant_d = sel;
        end
      end
      PKT: begin
        busy                  = 1'b1;
        bus.s_tdata           = bus.m_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        bus.s_tvalid          = bus.m_tvalid[grant_q];
        bus.s_tlast           = bus.m_tlast[grant_q];
        bus.s_tid             = grant_q;
        bus.m_tready[grant_q] = bus.s_tready;
        eop = bus.m_tvalid[grant_q] & bus.s_tready & bus.m_tlast[grant_q];
        // Leaving through IDLE guarantees the one-cycle bubble before the next grant.
        if (eop) begin
          state_d    = IDLE;
          rr_ptr_d   = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
          pkt_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pkt_done = pkt_done_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      pkt_done_q <= pkt_done_d;
    end
  end
endmodule
